// File: rtl/wb_pkg.sv
// Shared constants for the writeback selector: source select codes and the
// constant word returned for the "constant" select code.
package wb_pkg;

    localparam int SEL_HI     = 0;
    localparam int SEL_LO     = 1;
    localparam int SEL_RESULT = 2;
    localparam int SEL_LS     = 3;
    localparam int SEL_LUI    = 4;
    localparam int SEL_ALU    = 5;
    localparam int SEL_SHIFT  = 6;
    localparam int SEL_SEXT1  = 7;
    localparam int SEL_CONST  = 8;

    localparam int WB_CONST   = 227;

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for writeback entries: circular buffer with read/write
// pointers and an occupancy count. The caller guarantees push only when not
// full and pop only when not empty. With WB_BYPASS_EN defined the raw storage
// and read pointer are exported so the top level can search queued entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DATA_W = 37,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
`ifdef WB_BYPASS_EN
    ,
    output logic [DEPTH*DATA_W-1:0] stor,
    output logic [PTR_W-1:0]        rd_idx
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage; contents need no reset because count gates the output.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Head word, forced to zero while empty.
    always_comb begin
        rd_data = (count != '0) ? mem[rd_ptr] : '0;
    end

`ifdef WB_BYPASS_EN
    // Flattened view of the storage for the bypass search.
    always_comb begin
        stor = '0;
        for (int i = 0; i < DEPTH; i++) stor[i*DATA_W +: DATA_W] = mem[i];
        rd_idx = rd_ptr;
    end
`endif

endmodule

// File: rtl/wb_select_queue.sv
// Writeback selector + in-order queue. Selects a source word (or the constant)
// by select code, filters writes to register 0, tracks a sticky bad-select
// flag and drains queued {addr, data} entries to the register file.
// Optional macro WB_BYPASS_EN adds a combinational lookup of queued entries
// (byp_addr / byp_hit / byp_data).
module wb_select_queue
    import wb_pkg::*;
#(
    parameter  int W         = 32,
    parameter  int N_SRC     = 8,
    parameter  int SEL_W     = 4,
    parameter  int ADDR_W    = 5,
    parameter  int DEPTH     = 2,
    parameter  int CONST_VAL = WB_CONST,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC*W-1:0] src_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W-1:0]       wb_data,
    output logic [ADDR_W-1:0]  wb_addr,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic               sel_err,
    output logic [CNT_W-1:0]   occupancy
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]  byp_addr,
    output logic               byp_hit,
    output logic [W-1:0]       byp_data
`endif
);

    localparam int DATA_W = ADDR_W + W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]      sel_word;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // Source select: explicit compare per code keeps out-of-range codes at zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) sel_word = src_data[k*W +: W];
        end
        if (sel == SEL_W'(N_SRC)) sel_word = W'(CONST_VAL);
    end

    // Handshakes; a register-0 destination completes the handshake but is dropped.
    always_comb begin
        in_ready = (occupancy != CNT_W'(DEPTH));
        accept   = in_valid && in_ready;
        push     = accept && (dst_addr != '0);
        wb_valid = (occupancy != '0);
        pop      = wb_valid && wb_ready;
        wb_addr  = head[W +: ADDR_W];
        wb_data  = head[W-1:0];
    end

    // Sticky flag for any accepted select code beyond the constant slot.
    always_ff @(posedge clk) begin
        if (reset)                                sel_err <= 1'b0;
        else if (accept && sel > SEL_W'(N_SRC))   sel_err <= 1'b1;
    end

`ifdef WB_BYPASS_EN
    logic [DEPTH*DATA_W-1:0] stor;
    logic [PTR_W-1:0]        rd_idx;
`endif

    wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({dst_addr, sel_word}),
        .rd_data (head),
        .count   (occupancy)
`ifdef WB_BYPASS_EN
        ,
        .stor    (stor),
        .rd_idx  (rd_idx)
`endif
    );

`ifdef WB_BYPASS_EN
    // Walk stored entries oldest to youngest so the youngest match wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            int j;
            j = int'(rd_idx) + i;
            if (j >= DEPTH) j = j - DEPTH;
            if (i < int'(occupancy) && byp_addr != '0 &&
                stor[j*DATA_W + W +: ADDR_W] == byp_addr) begin
                byp_hit  = 1'b1;
                byp_data = stor[j*DATA_W +: W];
            end
        end
    end
`endif

endmodule
